// File: rtl/axi_burst_addr_gen_if.sv
// Command and beat channel bundle for axi_burst_addr_gen.
// slave: the address generator's view. master: the driving side's view.
interface axi_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ID_WIDTH-1:0]   cmd_id_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [7:0]            cmd_len_i;
  logic [2:0]            cmd_size_i;
  logic [1:0]            cmd_burst_i;

  logic                  beat_valid_o;
  logic                  beat_ready_i;
  logic [ID_WIDTH-1:0]   beat_id_o;
  logic [ADDR_WIDTH-1:0] beat_addr_o;
  logic [7:0]            beat_idx_o;
  logic                  beat_last_o;
  logic                  beat_err_o;

  modport slave (
    input  cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    input  beat_ready_i,
    output cmd_ready_o,
    output beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
  );

  modport master (
    output cmd_valid_i, cmd_id_i, cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i,
    output beat_ready_i,
    input  cmd_ready_o,
    input  beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o, beat_err_o
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: turns one accepted AW/AR command into its
// per-beat address sequence (FIXED / INCR / WRAP) and flags illegal commands.
// Illegal commands still produce len+1 beats, all at the start address.
// Optional macro AXI_BURST_4KB_CHECK_EN: also flags INCR bursts crossing a
// 4KB boundary (addresses are still generated as INCR).
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_burst_addr_gen_if.slave  bus
);

  localparam int         MAX_SIZE    = $clog2(DATA_WIDTH / 8);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, lower_q, wsize_q;
  logic [7:0]            idx_q, len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q, hold_q;

  logic                  cmd_hs, beat_hs, beat_last;
  logic [8:0]            cmd_beats;
  logic [ADDR_WIDTH-1:0] cmd_bytes, cmd_mask, cmd_wsize;
  logic                  err_base, err_4k;
  logic [ADDR_WIDTH-1:0] beat_bytes, incr_addr, next_addr;

  assign beat_last = (state_q == BURST) && (idx_q == len_q);
  assign beat_hs   = (state_q == BURST) && bus.beat_ready_i;
  assign cmd_hs    = bus.cmd_valid_i && bus.cmd_ready_o;

  assign bus.cmd_ready_o  = (state_q == IDLE) || (beat_hs && beat_last);
  assign bus.beat_valid_o = (state_q == BURST);
  assign bus.beat_last_o  = beat_last;
  assign bus.beat_addr_o  = addr_q;
  assign bus.beat_idx_o   = idx_q;
  assign bus.beat_id_o    = id_q;
  assign bus.beat_err_o   = err_q;

  assign cmd_beats = {1'b0, bus.cmd_len_i} + 9'd1;
  assign cmd_bytes = ADDR_WIDTH'(1) << bus.cmd_size_i;
  assign cmd_mask  = cmd_bytes - ADDR_WIDTH'(1);
  assign cmd_wsize = ADDR_WIDTH'(cmd_beats) << bus.cmd_size_i;

  // Legality checks on the incoming command that force the burst to the start address.
  always_comb begin
    err_base = 1'b0;
    if (bus.cmd_burst_i == 2'b11)
      err_base = 1'b1;
    if (int'(bus.cmd_size_i) > MAX_SIZE)
      err_base = 1'b1;
    if (bus.cmd_burst_i == BURST_WRAP) begin
      if (!(bus.cmd_len_i == 8'd1 || bus.cmd_len_i == 8'd3 ||
            bus.cmd_len_i == 8'd7 || bus.cmd_len_i == 8'd15))
        err_base = 1'b1;
      if ((bus.cmd_addr_i & cmd_mask) != '0)
        err_base = 1'b1;
    end
    if (bus.cmd_burst_i == BURST_FIXED && bus.cmd_len_i > 8'd15)
      err_base = 1'b1;
  end

`ifdef AXI_BURST_4KB_CHECK_EN
  logic [16:0] page_off, page_span;
  assign page_off  = {5'b0, bus.cmd_addr_i[11:0] & ~cmd_mask[11:0]};
  assign page_span = 17'(cmd_beats) << bus.cmd_size_i;
  assign err_4k    = (bus.cmd_burst_i == BURST_INCR) && ((page_off + page_span) > 17'd4096);
`else
  assign err_4k    = 1'b0;
`endif

  assign beat_bytes = ADDR_WIDTH'(1) << size_q;
  assign incr_addr  = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;

  // Address of the following beat: held, incrementing, or wrapping back to the lower bound.
  always_comb begin
    next_addr = incr_addr;
    if (hold_q)
      next_addr = addr_q;
    else if (burst_q == BURST_WRAP && incr_addr == lower_q + wsize_q)
      next_addr = lower_q;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: back-to-back bursts stay in BURST with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_hs) state_d = BURST;
      BURST:   if (beat_hs && beat_last) state_d = cmd_hs ? BURST : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture on acceptance and per-beat address/index advance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      lower_q <= '0;
      wsize_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else if (cmd_hs) begin
      addr_q  <= bus.cmd_addr_i;
      lower_q <= bus.cmd_addr_i & ~(cmd_wsize - ADDR_WIDTH'(1));
      wsize_q <= cmd_wsize;
      idx_q   <= '0;
      len_q   <= bus.cmd_len_i;
      size_q  <= bus.cmd_size_i;
      burst_q <= bus.cmd_burst_i;
      id_q    <= bus.cmd_id_i;
      err_q   <= err_base || err_4k;
      hold_q  <= err_base || (bus.cmd_burst_i == BURST_FIXED);
    end else if (beat_hs && !beat_last) begin
      addr_q  <= next_addr;
      idx_q   <= idx_q + 8'd1;
    end
  end

endmodule
